simd_alu_arbiter: RTL and testbench
===================================

// Module: simd_alu_arbiter
// PURPOSE
//  Shares one SIMD_ALU (256-bit, 16-bit inst = opcode[15:12], dm[11:9], immf[8], imm[7:0]) among NREQ requesters.
//  Round-robin grant, one operation in flight, fixed ALU pipeline latency tracked by counter.
//  Returns result tagged with requester id over a valid/ready response channel.
//  Sits between issue sources (sequencers/DMA) and the SIMD_ALU instance.
// PARAMETERS
//  NREQ     4    number of requesters (2..8)
//  DATA_W   256  operand/result width
//  INST_W   16   instruction width
//  ALU_LAT  1    cycles from ALU input sampling edge to valid out (>=1)
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              asynchronous reset, active-low
//  req_valid  in   NREQ           request valid per requester
//  req_ready  out  NREQ           one-hot grant/accept, combinational
//  req_inst   in   NREQ*INST_W    flat instructions, requester i at [i*INST_W +: INST_W]
//  req_a      in   NREQ*DATA_W    flat operand A
//  req_b      in   NREQ*DATA_W    flat operand B
//  alu_inst   out  INST_W         to SIMD_ALU.inst, registered
//  alu_a      out  DATA_W         to SIMD_ALU.in_A, registered
//  alu_b      out  DATA_W         to SIMD_ALU.in_B, registered
//  alu_out    in   DATA_W         from SIMD_ALU.out
//  rsp_valid  out  1              response valid
//  rsp_ready  in   1              response accept
//  rsp_id     out  $clog2(NREQ)   requester id of response
//  rsp_data   out  DATA_W         ALU result
//  rsp_err    out  1              illegal-opcode flag, 0 without macro
// BEHAVIOUR
//  Reset (rst=0, any time, incl. mid-op): state IDLE, rr pointer 0, all outputs 0, in-flight op dropped.
//  alu_inst=0 is NOP, so the ALU is idle.
//  FSM states:
//   IDLE:  if any req_valid, grant first valid at/after rr ptr. req_ready[g]=1 this cycle only.
//          Capture inst/a/b/id, set ptr=g+1 mod NREQ, go ISSUE.
//   ISSUE: drive alu_* from captured regs, cnt=ALU_LAT-1, go WAIT.
//   WAIT:  hold alu_* stable. At cnt==0, capture alu_out into rsp_data and go RESP; else cnt--.
//   RESP:  rsp_valid=1; alu_* = 0 (NOP).
//          rsp_id/rsp_data/rsp_err stable until rsp_ready=1, then go IDLE with rsp_valid=0 next cycle.
//  Timing: grant cycle T; rsp_valid first high in cycle T+2+ALU_LAT. Next grant no earlier than the cycle after handshake.
//  req_ready is 0 in all states except IDLE. A requester dropping valid before grant is never granted.
//  No pointer advance without a grant. Pointer wraps NREQ-1 -> 0.
// CONFIGURATION
//  SIMD_ARB_ILLEGAL_OP_TRAP_EN defined:
//   Opcode 4'hA..4'hF at grant goes IDLE -> RESP directly, with rsp_err=1 and rsp_data=0.
//   The ALU keeps NOP throughout.
//  Undefined: every opcode is forwarded unchanged; rsp_err tied 0.
// STRUCTURE
//  simd_alu_pkg: opcode localparams (NOP=0, PADD=1, PSUB=2, PSLL=3, PSRL=4, PSRA=5,
//   PCMPEQ=6, PCMPGT=7, UNPKLO=8, UNPKHI=9), inst field slices, state enum.
//  Sub-module rr_arbiter #(NREQ): req, ptr -> one-hot grant + index, combinational.
// TESTING
//  1 Single req1 PADD8 inst 16'h10CC, A={256{1'b1}}, B={128{2'b10}}
//    -> rsp_id=1, rsp_data={32{8'hA9}} at T+3 (ALU_LAT=1).
//  2 All 4 valid continuously, inst 16'h20CC -> grants 0,1,2,3,0 in order;
//    rsp_data={64{4'b0011}} each.
//  3 rsp_ready low 5 cycles in RESP -> rsp_valid/id/data stable, req_ready all 0,
//    alu_inst=0; accept on 6th cycle.
//  4 req0 inst 16'hA000 -> macro on: rsp_err=1, rsp_data=0 at T+1, alu_inst stays 0;
//    macro off: forwarded, rsp_err=0.
//  5 rst low during WAIT for req2 -> all outputs 0, no response for req2;
//    after release req2 re-request is granted (ptr=0 path) and completes.
//  6 req3 inst 0 (NOP) -> rsp_id=3, rsp_data=0; ptr wraps to 0, next grant req0 over req1.

Source files
------------

// File: rtl/simd_alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// simd_alu_pkg : SIMD_ALU opcodes, instruction field positions, arbiter states
// Revision     : 1.0
// ---------------------------------------------------------------------------
package simd_alu_pkg;

  localparam logic [3:0] c_OP_NOP    = 4'h0;
  localparam logic [3:0] c_OP_PADD   = 4'h1;
  localparam logic [3:0] c_OP_PSUB   = 4'h2;
  localparam logic [3:0] c_OP_PSLL   = 4'h3;
  localparam logic [3:0] c_OP_PSRL   = 4'h4;
  localparam logic [3:0] c_OP_PSRA   = 4'h5;
  localparam logic [3:0] c_OP_PCMPEQ = 4'h6;
  localparam logic [3:0] c_OP_PCMPGT = 4'h7;
  localparam logic [3:0] c_OP_UNPKLO = 4'h8;
  localparam logic [3:0] c_OP_UNPKHI = 4'h9;

  // inst = opcode[15:12], dm[11:9], immf[8], imm[7:0]
  localparam int c_INST_OPC_MSB = 15;
  localparam int c_INST_OPC_LSB = 12;
  localparam int c_INST_DM_MSB  = 11;
  localparam int c_INST_DM_LSB  = 9;
  localparam int c_INST_IMMF    = 8;
  localparam int c_INST_IMM_MSB = 7;
  localparam int c_INST_IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  function automatic logic is_illegal_op(input logic [3:0] opc);
    return (opc > c_OP_UNPKHI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/simd_alu_arbiter_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick of the first request at/after ptr
// Revision   : 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  localparam logic [IDX_W:0] c_NREQ = (IDX_W + 1)'(NREQ);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_slot;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    w_sum     = '0;
    w_slot    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr + k folded back into 0..NREQ-1 without a divider
      w_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (w_sum >= c_NREQ) begin
        w_sum = w_sum - c_NREQ;
      end
      w_slot = w_sum[IDX_W-1:0];
      if (!grant_any && req[w_slot]) begin
        grant[w_slot] = 1'b1;
        grant_idx     = w_slot;
        grant_any     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/simd_alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// simd_alu_arbiter : round-robin sharing of one SIMD_ALU, one op in flight.
// Optional illegal-opcode trap: SIMD_ARB_ILLEGAL_OP_TRAP_EN.   Revision: 1.0
// ---------------------------------------------------------------------------
module simd_alu_arbiter
  import simd_alu_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int DATA_W  = 256,
  parameter  int INST_W  = 16,
  parameter  int ALU_LAT = 1,
  localparam int IDX_W   = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*INST_W-1:0]   req_inst,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  output logic [INST_W-1:0]        alu_inst,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  input  logic [DATA_W-1:0]        alu_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDX_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err
);

  localparam int               c_CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [IDX_W-1:0] c_LAST  = IDX_W'(NREQ - 1);

  logic [INST_W-1:0] w_inst [NREQ];
  logic [DATA_W-1:0] w_a    [NREQ];
  logic [DATA_W-1:0] w_b    [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_inst[gi] = req_inst[gi*INST_W +: INST_W];
    assign w_a[gi]    = req_a[gi*DATA_W +: DATA_W];
    assign w_b[gi]    = req_b[gi*DATA_W +: DATA_W];
  end

  arb_state_t        r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_id;
  logic [INST_W-1:0] r_inst;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [c_CNT_W-1:0] r_cnt;

  logic [NREQ-1:0]  w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_idx),
    .grant_any (w_any)
  );

  assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;

`ifdef SIMD_ARB_ILLEGAL_OP_TRAP_EN
  logic r_err;
  logic w_trap;
  assign w_trap  = is_illegal_op(w_inst[w_idx][INST_W-1 -: 4]);
  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_inst    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      alu_inst  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
`ifdef SIMD_ARB_ILLEGAL_OP_TRAP_EN
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_inst <= w_inst[w_idx];
            r_a    <= w_a[w_idx];
            r_b    <= w_b[w_idx];
            r_id   <= w_idx;
            r_ptr  <= (w_idx == c_LAST) ? '0 : w_idx + 1'b1;
`ifdef SIMD_ARB_ILLEGAL_OP_TRAP_EN
            // Trapped ops never reach the ALU, which keeps seeing NOP
            if (w_trap) begin
              rsp_valid <= 1'b1;
              rsp_id    <= w_idx;
              rsp_data  <= '0;
              r_err     <= 1'b1;
              r_state   <= ST_RESP;
            end else begin
              r_state <= ST_ISSUE;
            end
`else
            r_state <= ST_ISSUE;
`endif
          end
        end
        ST_ISSUE: begin
          alu_inst <= r_inst;
          alu_a    <= r_a;
          alu_b    <= r_b;
          r_cnt    <= c_CNT_W'(ALU_LAT - 1);
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_id    <= r_id;
            rsp_data  <= alu_out;
`ifdef SIMD_ARB_ILLEGAL_OP_TRAP_EN
            r_err     <= 1'b0;
`endif
            alu_inst  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simd_alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_simd_alu_arbiter : scoreboard bench with a behavioural SIMD_ALU stub
// Revision            : 1.0
// ---------------------------------------------------------------------------
module tb_simd_alu_arbiter;

  localparam int NREQ    = 4;
  localparam int DATA_W  = 256;
  localparam int INST_W  = 16;
  localparam int ALU_LAT = 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*INST_W-1:0] req_inst = '0;
  logic [NREQ*DATA_W-1:0] req_a = '0;
  logic [NREQ*DATA_W-1:0] req_b = '0;
  logic [INST_W-1:0]      alu_inst;
  logic [DATA_W-1:0]      alu_a;
  logic [DATA_W-1:0]      alu_b;
  logic [DATA_W-1:0]      alu_out;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic [1:0]             rsp_id;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rsp_err;

  always #5 clk = ~clk;

  simd_alu_arbiter #(
    .NREQ(NREQ), .DATA_W(DATA_W), .INST_W(INST_W), .ALU_LAT(ALU_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_inst(req_inst), .req_a(req_a), .req_b(req_b),
    .alu_inst(alu_inst), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Behavioural SIMD_ALU: PADD/PSUB on byte lanes, NOP gives 0, others a mixing function
  function automatic logic [255:0] alu_fn(input logic [15:0] inst,
                                          input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    r = '0;
    case (inst[15:12])
      4'h0: r = '0;
      4'h1: for (int k = 0; k < 32; k++) r[k*8 +: 8] = a[k*8 +: 8] + b[k*8 +: 8];
      4'h2: for (int k = 0; k < 32; k++) r[k*8 +: 8] = a[k*8 +: 8] - b[k*8 +: 8];
      default: r = a ^ {b[254:0], 1'b0} ^ {16{inst}};
    endcase
    return r;
  endfunction

  assign alu_out = alu_fn(alu_inst, alu_a, alu_b);

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  function automatic void chk(input bit ok, input string name,
                              input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           id;
    logic [255:0] data;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t            exp_q[$];
  int              rsp_log[$];
  logic [NREQ-1:0] granted_mask = '0;

  // Reference model: round-robin over requester indices, one op until handshake
  initial begin : p_model
    int           m_ptr;
    bit           m_busy;
    bit           m_trap;
    int           m_grant;
    int           m_rsp;
    int           g;
    logic [15:0]  m_inst;
    logic [NREQ-1:0] exp_ready;
    exp_t         e;
    m_ptr = 0; m_busy = 0; m_trap = 0; m_grant = 0; m_rsp = 0; m_inst = '0;
    forever begin
      @(negedge clk);
      granted_mask = '0;
      if (!rst) begin
        m_ptr = 0;
        m_busy = 0;
        exp_q.delete();
        chk(req_ready == '0, "rst_req_ready", req_ready, 0);
        chk(rsp_valid == 1'b0 && rsp_err == 1'b0 && rsp_id == '0, "rst_rsp_ctl",
            {rsp_valid, rsp_err, rsp_id}, 0);
        chk(rsp_data == '0, "rst_rsp_data", rsp_data, 0);
        chk(alu_inst == '0 && alu_a == '0 && alu_b == '0, "rst_alu",
            alu_inst | alu_a | alu_b, 0);
      end else begin
        exp_ready = '0;
        g = -1;
        if (!m_busy) begin
          for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
          end
          if (g >= 0) exp_ready[g] = 1'b1;
        end
        chk(req_ready == exp_ready, "req_ready", req_ready, exp_ready);
        if (m_busy) begin
          if (m_trap || cyc >= m_rsp)
            chk(alu_inst == '0, "alu_nop", alu_inst, 0);
          else if (cyc >= m_grant + 2)
            chk(alu_inst == m_inst, "alu_inst_hold", alu_inst, m_inst);
          if (cyc >= m_rsp && rsp_ready) m_busy = 0;
        end else if (g >= 0) begin
          m_inst  = req_inst[g*INST_W +: INST_W];
`ifdef SIMD_ARB_ILLEGAL_OP_TRAP_EN
          m_trap  = (m_inst[15:12] >= 4'hA);
`else
          m_trap  = 1'b0;
`endif
          m_busy  = 1;
          m_grant = cyc;
          m_rsp   = m_trap ? cyc + 1 : cyc + 2 + ALU_LAT;
          e.id    = g;
          e.err   = m_trap;
          e.data  = m_trap ? '0 : alu_fn(m_inst, req_a[g*DATA_W +: DATA_W],
                                         req_b[g*DATA_W +: DATA_W]);
          e.cyc   = m_rsp;
          exp_q.push_back(e);
          granted_mask[g] = 1'b1;
          m_ptr = (g + 1) % NREQ;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a new response appears
  initial begin : p_monitor
    exp_t cur;
    bit   have;
    have = 0;
    cur  = '{id: 0, data: '0, err: 1'b0, cyc: 0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        have = 0;
      end else if (rsp_valid) begin
        if (!have) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "rsp_unexpected", rsp_id, 0);
          end else begin
            cur  = exp_q.pop_front();
            have = 1;
            rsp_log.push_back(int'(rsp_id));
            chk(cyc == cur.cyc, "rsp_latency", cyc, cur.cyc);
            chk(rsp_id == cur.id[1:0], "rsp_id", rsp_id, cur.id);
            chk(rsp_data == cur.data, "rsp_data", rsp_data, cur.data);
            chk(rsp_err == cur.err, "rsp_err", rsp_err, cur.err);
          end
        end else begin
          chk(rsp_id == cur.id[1:0] && rsp_data == cur.data && rsp_err == cur.err,
              "rsp_hold", {rsp_err, rsp_id}, {cur.err, cur.id[1:0]});
        end
        if (rsp_ready) have = 0;
      end else begin
        if (have) begin
          chk(1'b0, "rsp_dropped", 0, 1);
          have = 0;
        end
        if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
          chk(1'b0, "rsp_missing", cyc, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // A requester releases valid once the model has granted it
  initial forever begin
    @(posedge clk);
    #1;
    req_valid = req_valid & ~granted_mask;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_req(input int i, input logic [15:0] inst,
                         input logic [255:0] a, input logic [255:0] b);
    req_inst[i*INST_W +: INST_W] = inst;
    req_a[i*DATA_W +: DATA_W]    = a;
    req_b[i*DATA_W +: DATA_W]    = b;
    req_valid[i]                 = 1'b1;
  endtask

  task automatic wait_rsp(input string name, output bit ok);
    ok = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(1'b0, name, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin : p_driver
    bit ok;
    int exp_order [5];
    int n;
    exp_order = '{0, 1, 2, 3, 0};
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // All four requesters continuously valid, PSUB byte lanes 0x77-0x44
    rsp_log.delete();
    n = 0;
    while (rsp_log.size() < 5 && n < 80) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i]) set_req(i, 16'h20CC, {32{8'h77}}, {32{8'h44}});
      tick();
      n++;
    end
    req_valid = '0;
    repeat (8) tick();
    chk(rsp_log.size() >= 5, "rr_count", rsp_log.size(), 5);
    for (int k = 0; k < 5 && k < rsp_log.size(); k++)
      chk(rsp_log[k] == exp_order[k], "rr_order", rsp_log[k], exp_order[k]);

    // Single PADD from requester 1
    set_req(1, 16'h10CC, {256{1'b1}}, {128{2'b10}});
    wait_rsp("t1_timeout", ok);
    if (ok) begin
      chk(rsp_id == 2'd1, "t1_id", rsp_id, 1);
      chk(rsp_data == {32{8'hA9}}, "t1_data", rsp_data, {32{8'hA9}});
    end
    repeat (4) tick();

    // Response back-pressure for six cycles with another requester waiting
    rsp_ready = 1'b0;
    set_req(2, 16'h10CC, rand256(), rand256());
    wait_rsp("t3_timeout", ok);
    tick();
    set_req(0, 16'h20CC, rand256(), rand256());
    repeat (3) tick();
    tick();
    rsp_ready = 1'b1;
    repeat (12) tick();

    // Opcode 0xA
    set_req(0, 16'hA000, rand256(), rand256());
    wait_rsp("t4_timeout", ok);
    if (ok) begin
`ifdef SIMD_ARB_ILLEGAL_OP_TRAP_EN
      chk(rsp_err == 1'b1, "t4_err", rsp_err, 1);
      chk(rsp_data == '0, "t4_data", rsp_data, 0);
`else
      chk(rsp_err == 1'b0, "t4_err", rsp_err, 0);
`endif
    end
    repeat (4) tick();

    // Reset while requester 2 is in WAIT
    set_req(2, 16'h10CC, rand256(), rand256());
    n = 0;
    while (req_valid[2] && n < 20) begin
      tick();
      n++;
    end
    chk(!req_valid[2], "t5_grant", req_valid[2], 0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    set_req(2, 16'h10CC, rand256(), rand256());
    wait_rsp("t5_timeout", ok);
    if (ok) chk(rsp_id == 2'd2, "t5_id", rsp_id, 2);
    tick();

    // NOP from requester 3, pointer wraps, then 0 wins over 1
    set_req(3, 16'h0000, rand256(), rand256());
    wait_rsp("t6_timeout", ok);
    if (ok) begin
      chk(rsp_id == 2'd3, "t6_id", rsp_id, 3);
      chk(rsp_data == '0, "t6_data", rsp_data, 0);
    end
    tick();
    set_req(0, 16'h10CC, rand256(), rand256());
    set_req(1, 16'h10CC, rand256(), rand256());
    wait_rsp("t6b_timeout", ok);
    if (ok) chk(rsp_id == 2'd0, "t6_wrap", rsp_id, 0);
    repeat (10) tick();

    // Randomized traffic with withdrawals and random back-pressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 16'($urandom), rand256(), rand256());
        else if (req_valid[i] && $urandom_range(0, 19) == 0)
          req_valid[i] = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (20) tick();
    chk(exp_q.size() == 0, "drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
